sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter FAIR_LIMIT, default 4, is the number of consecutive data-side grants allowed while inst_req is pending before inst wins.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req  in  1  fetch-side read request; held until inst_addr_ok.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  fetch request accepted (1-cycle pulse).
REQ-007 inst_data_ok  out  1  fetch read data valid (1-cycle pulse).
REQ-008 inst_rdata  out  32  fetch read data, valid with inst_data_ok.
REQ-009 data_req  in  1  load/store request from EXE/MEM; held until data_addr_ok.
REQ-010 data_wr  in  1  1 = store, 0 = load.
REQ-011 data_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_wstrb  in  4  store byte enables.
REQ-013 data_addr  in  32  load/store address.
REQ-014 data_wdata  in  32  store data.
REQ-015 data_addr_ok  out  1  load/store request accepted (pulse).
REQ-016 data_data_ok  out  1  load data returned / store completed (pulse).
REQ-017 data_rdata  out  32  load data, valid with data_data_ok.
REQ-018 bus_req, bus_wr, bus_size[1:0], bus_wstrb[3:0], bus_addr[31:0], bus_wdata[31:0]  out  shared SRAM-like request channel.
REQ-019 bus_addr_ok, bus_data_ok  in  1 each  slave handshakes; bus_rdata  in  32  slave read data.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states are IDLE, ADDR and DATA, with one outstanding transaction at most.
REQ-022 In IDLE, if any request is pending, the arbiter SHALL latch the winner id and all of its request fields into registers and go to ADDR next cycle; otherwise it stays in IDLE.
REQ-023 Arbitration: data wins over inst; when data_req and inst_req are both high and fair_cnt == FAIR_LIMIT, inst wins.
REQ-024 fair_cnt: increments (saturating at FAIR_LIMIT) on each data grant made while inst_req=1; clears on any inst grant or when inst_req=0 at arbitration; width = clog2(FAIR_LIMIT+1).
REQ-025 In ADDR, bus_req=1 and the bus_* fields are driven from the latched registers; inst side: bus_wr=0, bus_size=2, bus_wstrb=0, bus_wdata=0.
REQ-026 In ADDR, on bus_addr_ok=1 the arbiter SHALL pulse the winner's *_addr_ok combinationally in that same cycle and go to DATA.
REQ-027 In DATA, bus_req=0; on bus_data_ok=1 the arbiter SHALL pulse the winner's *_data_ok, drive bus_rdata onto the winner's *_rdata combinationally, and go to IDLE.
REQ-028 Minimum latency: request in cycle n, bus_req in n+1, master addr_ok ≥ n+1, one IDLE bubble between transactions.
REQ-029 bus_addr_ok outside ADDR and bus_data_ok outside DATA SHALL be ignored, with no master pulse.
REQ-030 The non-winning master never receives addr_ok or data_ok.
REQ-031 Master fields changing after latching do not affect the bus transaction.
REQ-032 A master dropping req while in ADDR does not abort the transaction.
REQ-033 *_rdata = 0 when the matching *_data_ok = 0.

Reset
REQ-034 While resetn=0: state=IDLE, fair_cnt=0, latched fields=0; all outputs 0, including bus_req, every addr_ok/data_ok and busy.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion pulse after release.
REQ-036 The first arbitration is possible in the first posedge after resetn rises.

Verification
REQ-037 Single load: data_req, addr=0x1000_0004, wr=0; slave addr_ok at next cycle, data_ok 2 cycles later with rdata=0xDEADBEEF -> bus_addr=0x1000_0004, data_addr_ok 1 pulse, data_data_ok with data_rdata=0xDEADBEEF, inst outputs stay 0.
REQ-038 Simultaneous inst_req (0x1C00_0000) and data store (addr 0x20, wstrb=0xF, wdata=0x12345678) -> data granted first with bus_wr=1; inst granted on the next IDLE.
REQ-039 Starvation: data_req and inst_req held continuously, FAIR_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-040 Slave stalls addr_ok 5 cycles, with spurious bus_data_ok in ADDR -> bus_req held steady for 5 cycles, no data_ok pulse to either master.
REQ-041 resetn low during DATA, then a late bus_data_ok after release -> all outputs 0 during reset, no data_ok pulse, state IDLE.
REQ-042 Master changes data_addr after latching but before bus_addr_ok -> bus_addr keeps the latched value.

Source files
------------

// File: rtl/sram_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
//
// Two-master arbiter for a single SRAM-like bus. The fetch side (inst_*) is
// read-only; the load/store side (data_*) may read or write. Only one
// transaction is ever outstanding. The data side normally wins. After
// FAIR_LIMIT consecutive data grants while a fetch is waiting, the fetch
// wins once.
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   inst_req/inst_addr       fetch request (held until inst_addr_ok)
//   inst_addr_ok             fetch request accepted (pulse)
//   inst_data_ok/inst_rdata  fetch read data (pulse, data valid with it)
//   data_req/wr/size/wstrb/addr/wdata
//                            load/store request (held until data_addr_ok)
//   data_addr_ok             load/store request accepted (pulse)
//   data_data_ok/data_rdata  load data / store completion (pulse)
//   bus_req/wr/size/wstrb/addr/wdata
//                            shared request channel towards the slave
//   bus_addr_ok/bus_data_ok/bus_rdata
//                            slave handshakes and read data
//   busy                     high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module sram_arb #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        busy
);

    localparam int            FW       = $clog2(FAIR_LIMIT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [FW-1:0] fairCnt_q, fairCnt_d;
    logic          winInst_q, winInst_d;
    logic          wr_q,      wr_d;
    logic [1:0]    size_q,    size_d;
    logic [3:0]    wstrb_q,   wstrb_d;
    logic [31:0]   addr_q,    addr_d;
    logic [31:0]   wdata_q,   wdata_d;

    logic          grantInst;
    logic          grantData;

    // Data has priority unless the fetch side has already been passed over
    // FAIR_LIMIT times in a row.
    always_comb begin
        grantInst = inst_req && (!data_req || (fairCnt_q == FAIR_MAX));
        grantData = data_req && !grantInst;
    end

    // State register and latched request fields.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            fairCnt_q <= '0;
            winInst_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            wstrb_q   <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            fairCnt_q <= fairCnt_d;
            winInst_q <= winInst_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic. Request fields are captured only at arbitration so
    // later changes on the master side cannot disturb the bus transaction.
    always_comb begin
        state_d   = state_q;
        fairCnt_d = fairCnt_q;
        winInst_d = winInst_q;
        wr_d      = wr_q;
        size_d    = size_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            IDLE: begin
                if (grantInst) begin
                    state_d   = ADDR;
                    fairCnt_d = '0;
                    winInst_d = 1'b1;
                    wr_d      = 1'b0;
                    size_d    = 2'd2;
                    wstrb_d   = 4'd0;
                    addr_d    = inst_addr;
                    wdata_d   = 32'd0;
                end else if (grantData) begin
                    state_d   = ADDR;
                    winInst_d = 1'b0;
                    wr_d      = data_wr;
                    size_d    = data_size;
                    wstrb_d   = data_wstrb;
                    addr_d    = data_addr;
                    wdata_d   = data_wdata;
                    // Only count data grants that made a fetch wait.
                    if (!inst_req) begin
                        fairCnt_d = '0;
                    end else if (fairCnt_q != FAIR_MAX) begin
                        fairCnt_d = fairCnt_q + FW'(1);
                    end
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. Slave handshakes are only forwarded in the phase they belong
    // to, and only to the master that owns the current transaction.
    always_comb begin
        busy         = (state_q != IDLE);
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_wstrb    = 4'd0;
        bus_addr     = 32'd0;
        bus_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;

        case (state_q)
            ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = wr_q;
                bus_size  = size_q;
                bus_wstrb = wstrb_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                if (bus_addr_ok) begin
                    inst_addr_ok = winInst_q;
                    data_addr_ok = !winInst_q;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    if (winInst_q) begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = bus_rdata;
                    end else begin
                        data_data_ok = 1'b1;
                        data_rdata   = bus_rdata;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_arb
//
// Directed bench for sram_arb. Inputs change on the falling clock edge and
// outputs are sampled 1 ns later, so every check sees the state registered
// at the previous rising edge together with the inputs of the current cycle.
// Single-bit outputs are packed into one flags word so a whole cycle's
// handshake picture is compared at once.
// -----------------------------------------------------------------------------
module tb_sram_arb;

    localparam logic [31:0] F_DDOK = 32'h01;
    localparam logic [31:0] F_DAOK = 32'h02;
    localparam logic [31:0] F_IDOK = 32'h04;
    localparam logic [31:0] F_IAOK = 32'h08;
    localparam logic [31:0] F_BREQ = 32'h10;
    localparam logic [31:0] F_BUSY = 32'h20;
    localparam logic [31:0] F_WR   = 32'h40;

    logic        clk    = 1'b0;
    logic        resetn = 1'b1;

    logic        inst_req   = 1'b0;
    logic [31:0] inst_addr  = 32'd0;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req   = 1'b0;
    logic        data_wr    = 1'b0;
    logic [1:0]  data_size  = 2'd0;
    logic [3:0]  data_wstrb = 4'd0;
    logic [31:0] data_addr  = 32'd0;
    logic [31:0] data_wdata = 32'd0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata   = 32'd0;

    logic        busy;

    int vectorCount = 0;
    int missCount   = 0;

    sram_arb #(.FAIR_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flags();
        return {25'd0, bus_wr, busy, bus_req, inst_addr_ok, inst_data_ok,
                data_addr_ok, data_data_ok};
    endfunction

    // Drive one cycle's worth of inputs on the falling edge, then settle.
    task automatic applyStimulus(
        input logic        rst,
        input logic        iReq,
        input logic [31:0] iAddr,
        input logic        dReq,
        input logic        dWr,
        input logic [1:0]  dSize,
        input logic [3:0]  dWstrb,
        input logic [31:0] dAddr,
        input logic [31:0] dWdata,
        input logic        bAok,
        input logic        bDok,
        input logic [31:0] bRdata
    );
        @(negedge clk);
        resetn      = rst;
        inst_req    = iReq;
        inst_addr   = iAddr;
        data_req    = dReq;
        data_wr     = dWr;
        data_size   = dSize;
        data_wstrb  = dWstrb;
        data_addr   = dAddr;
        data_wdata  = dWdata;
        bus_addr_ok = bAok;
        bus_data_ok = bDok;
        bus_rdata   = bRdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expInst;

        $display("[TB] sram_arb directed run start");

        // Reset with every input busy: nothing may leak out.
        applyStimulus(0, 1, 32'h1C00_0000, 1, 1, 2'd2, 4'hF, 32'h40, 32'h55, 1, 1, 32'hFFFF_FFFF);
        checkOutput("rst_flags", flags(), 32'h0);
        checkOutput("rst_data_rdata", data_rdata, 32'h0);
        checkOutput("rst_inst_rdata", inst_rdata, 32'h0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        applyStimulus(0, 1, 32'h1C00_0000, 1, 1, 2'd2, 4'hF, 32'h40, 32'h55, 1, 1, 32'hFFFF_FFFF);
        checkOutput("rst_flags2", flags(), 32'h0);

        // Single load, requested in the cycle reset releases.
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd2, 4'h0, 32'h1000_0004, 32'h0, 0, 0, 32'h0);
        checkOutput("ld_idle_flags", flags(), 32'h0);
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd2, 4'h0, 32'h1000_0004, 32'h0, 1, 0, 32'h0);
        checkOutput("ld_addr_flags", flags(), F_BUSY | F_BREQ | F_DAOK);
        checkOutput("ld_bus_addr", bus_addr, 32'h1000_0004);
        checkOutput("ld_bus_size", 32'(bus_size), 32'd2);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h1111_1111);
        checkOutput("ld_wait_flags", flags(), F_BUSY);
        checkOutput("ld_wait_rdata", data_rdata, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        checkOutput("ld_data_flags", flags(), F_BUSY | F_DDOK);
        checkOutput("ld_data_rdata", data_rdata, 32'hDEAD_BEEF);
        checkOutput("ld_inst_rdata", inst_rdata, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hDEAD_BEEF);
        checkOutput("ld_after_flags", flags(), 32'h0);
        checkOutput("ld_after_rdata", data_rdata, 32'h0);

        // Simultaneous store and fetch: store first, fetch after the bubble.
        applyStimulus(1, 1, 32'h1C00_0000, 1, 1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 0, 0, 32'h0);
        checkOutput("st_idle_flags", flags(), 32'h0);
        applyStimulus(1, 1, 32'h1C00_0000, 1, 1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 1, 0, 32'h0);
        checkOutput("st_addr_flags", flags(), F_WR | F_BUSY | F_BREQ | F_DAOK);
        checkOutput("st_bus_addr", bus_addr, 32'h20);
        checkOutput("st_bus_wstrb", 32'(bus_wstrb), 32'hF);
        checkOutput("st_bus_wdata", bus_wdata, 32'h1234_5678);
        applyStimulus(1, 1, 32'h1C00_0000, 0, 1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 0, 1, 32'hAAAA_5555);
        checkOutput("st_data_flags", flags(), F_BUSY | F_DDOK);
        applyStimulus(1, 1, 32'h1C00_0000, 0, 1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 0, 0, 32'h0);
        checkOutput("if_bubble_flags", flags(), 32'h0);
        applyStimulus(1, 1, 32'h1C00_0000, 0, 1, 2'd2, 4'hF, 32'h20, 32'h1234_5678, 1, 0, 32'h0);
        checkOutput("if_addr_flags", flags(), F_BUSY | F_BREQ | F_IAOK);
        checkOutput("if_bus_addr", bus_addr, 32'h1C00_0000);
        checkOutput("if_bus_size", 32'(bus_size), 32'd2);
        checkOutput("if_bus_wstrb", 32'(bus_wstrb), 32'h0);
        checkOutput("if_bus_wdata", bus_wdata, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hCAFE_F00D);
        checkOutput("if_data_flags", flags(), F_BUSY | F_IDOK);
        checkOutput("if_inst_rdata", inst_rdata, 32'hCAFE_F00D);
        checkOutput("if_data_rdata", data_rdata, 32'h0);

        // Both masters request continuously: expected order D,D,D,D,I repeated.
        for (int t = 0; t < 10; t++) begin
            expInst = (t == 4) || (t == 9);
            applyStimulus(1, 1, 32'h1C00_0100, 1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 0, 0, 32'h0);
            checkOutput($sformatf("fair%0d_idle", t), flags(), 32'h0);
            applyStimulus(1, 1, 32'h1C00_0100, 1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 1, 0, 32'h0);
            checkOutput($sformatf("fair%0d_addr_ok", t), flags(),
                        expInst ? (F_BUSY | F_BREQ | F_IAOK) : (F_BUSY | F_BREQ | F_DAOK));
            checkOutput($sformatf("fair%0d_bus_addr", t), bus_addr,
                        expInst ? 32'h1C00_0100 : 32'h200);
            applyStimulus(1, 1, 32'h1C00_0100, 1, 0, 2'd2, 4'h0, 32'h200, 32'h0, 0, 1, 32'h0);
            checkOutput($sformatf("fair%0d_data_ok", t), flags(),
                        expInst ? (F_BUSY | F_IDOK) : (F_BUSY | F_DDOK));
        end

        // Slave stalls addr_ok, throws spurious data_ok, master changes address.
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd1, 4'h0, 32'h300, 32'h0, 0, 0, 32'h0);
        checkOutput("stall_idle_flags", flags(), 32'h0);
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1, 0, 32'h0, 1, 0, 2'd1, 4'h0, 32'hBAD0, 32'h0, 0, 1, 32'h5A5A_5A5A);
            checkOutput($sformatf("stall%0d_flags", s), flags(), F_BUSY | F_BREQ);
            checkOutput($sformatf("stall%0d_bus_addr", s), bus_addr, 32'h300);
            checkOutput($sformatf("stall%0d_rdata", s), data_rdata, 32'h0);
        end
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd1, 4'h0, 32'hBAD0, 32'h0, 1, 0, 32'h0);
        checkOutput("stall_aok_flags", flags(), F_BUSY | F_BREQ | F_DAOK);
        checkOutput("stall_aok_bus_addr", bus_addr, 32'h300);
        checkOutput("stall_aok_bus_size", 32'(bus_size), 32'd1);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("stall_spur_aok_flags", flags(), F_BUSY);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h0BAD_F00D);
        checkOutput("stall_dok_flags", flags(), F_BUSY | F_DDOK);
        checkOutput("stall_dok_rdata", data_rdata, 32'h0BAD_F00D);

        // Reset during DATA, then a late data_ok after release.
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd2, 4'h0, 32'h400, 32'h0, 0, 0, 32'h0);
        checkOutput("rd_idle_flags", flags(), 32'h0);
        applyStimulus(1, 0, 32'h0, 1, 0, 2'd2, 4'h0, 32'h400, 32'h0, 1, 0, 32'h0);
        checkOutput("rd_addr_flags", flags(), F_BUSY | F_BREQ | F_DAOK);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("rd_data_flags", flags(), F_BUSY);
        applyStimulus(0, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h77);
        checkOutput("rd_in_rst_flags", flags(), 32'h0);
        checkOutput("rd_in_rst_rdata", data_rdata, 32'h0);
        checkOutput("rd_in_rst_bus_addr", bus_addr, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h77);
        checkOutput("rd_late_dok_flags", flags(), 32'h0);
        checkOutput("rd_late_dok_rdata", data_rdata, 32'h0);
        applyStimulus(1, 0, 32'h0, 0, 0, 2'd0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("rd_settled_flags", flags(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
